slide_win_buf: RTL and testbench

SLIDE_WIN_BUF -- requirements
Module: slide_win_buf

---
 rtl/npu_pkg.sv | 18 +
 rtl/win_shift_array.sv | 73 +++++++
 rtl/slide_win_buf.sv | 154 +++++++++++++++
 tb/tb_slide_win_buf.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared types for the pixel-window datapath blocks.
// Holds the sliding-window FSM encoding and the scan-direction constants.
// No logic; imported by slide_win_buf and win_shift_array.
package npu_pkg;

  // FILL: fewer than K_W columns captured in the current row.
  // STREAM: the window is full, and each accepted column slides it.
  typedef enum logic {
    ST_FILL   = 1'b0,
    ST_STREAM = 1'b1
  } fsm_state_t;

  // DIR_FWD: new column enters at col 0, and older columns move to higher c.
  // DIR_REV: new column enters at col K_W-1, and older columns move to lower c.
  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

endpackage

// File: rtl/win_shift_array.sv
// K_H x K_W pixel shift array: each shift_en pushes in_col into one edge column.
// Latency: win_nxt is the combinational post-shift image; the state updates on the same edge.
// Backpressure: none of its own; the parent only raises shift_en on an accepted column.
// Ports: clk/rst_n (async low), clear (sync zero), shift_en, dir (DIR_FWD/DIR_REV),
//        in_col[r*DATA_W +: DATA_W], win_nxt[(r*K_W+c)*DATA_W +: DATA_W].
module win_shift_array
  import npu_pkg::*;
#(
  parameter int K_H    = 3,
  parameter int K_W    = 3,
  parameter int DATA_W = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        shift_en,
  input  logic                        dir,
  input  logic [K_H*DATA_W-1:0]       in_col,
  output logic [K_H*K_W*DATA_W-1:0]   win_nxt
);

  logic [DATA_W-1:0] win_q [K_H][K_W];
  logic [DATA_W-1:0] win_d [K_H][K_W];

  // Post-shift image. The parent decides whether to commit it, with shift_en,
  // and whether to snapshot it into the output register.
  always_comb begin
    for (int r = 0; r < K_H; r++) begin
      for (int c = 0; c < K_W; c++) begin
        win_d[r][c] = win_q[r][c];
      end
      if (dir == DIR_FWD) begin
        for (int c = 1; c < K_W; c++) begin
          win_d[r][c] = win_q[r][c-1];
        end
        win_d[r][0] = in_col[r*DATA_W +: DATA_W];
      end else begin
        for (int c = 0; c < K_W-1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
        win_d[r][K_W-1] = in_col[r*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    win_nxt = '0;
    for (int r = 0; r < K_H; r++) begin
      for (int c = 0; c < K_W; c++) begin
        win_nxt[(r*K_W+c)*DATA_W +: DATA_W] = win_d[r][c];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < K_H; r++) begin
        for (int c = 0; c < K_W; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else if (clear) begin
      for (int r = 0; r < K_H; r++) begin
        for (int c = 0; c < K_W; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else if (shift_en) begin
      win_q <= win_d;
    end
  end

endmodule

// File: rtl/slide_win_buf.sv
// Sliding K_H x K_W window buffer: builds windows from column beats and emits one every STRIDE columns.
// Latency: 1 cycle from the accepting edge to out_valid.
// Backpressure: a held, unaccepted window deasserts in_ready; clear also drops the offered column.
// Ports: clk, rst_n (async low), clear (sync flush); in_valid/in_ready/in_col/in_last/dir (column in);
//        out_valid/out_ready/out_win/out_dir/out_idx (window out; out_win[(r*K_W+c)*DATA_W +: DATA_W]).
module slide_win_buf
  import npu_pkg::*;
#(
  parameter int K_H    = 3,
  parameter int K_W    = 3,
  parameter int DATA_W = 8,
  parameter int STRIDE = 1,
  parameter int IDX_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [K_H*DATA_W-1:0]      in_col,
  input  logic                       in_last,
  input  logic                       dir,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [K_H*K_W*DATA_W-1:0]  out_win,
  output logic                       out_dir,
  output logic [IDX_W-1:0]           out_idx
);

  localparam int FILL_W = $clog2(K_W + 1);
  localparam int STR_W  = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  fsm_state_t                  state_q, state_d;
  logic                        rdy_en;
  logic [FILL_W-1:0]           fill_cnt;
  logic [STR_W-1:0]            stride_cnt;
  logic [IDX_W-1:0]            win_cnt;
  logic                        dir_q;
  logic                        dir_eff;
  logic                        accept;
  logic                        full_nxt;
  logic                        emit;
  logic [K_H*K_W*DATA_W-1:0]   win_nxt;

  // rdy_en keeps in_ready low during reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en <= 1'b0;
    else        rdy_en <= 1'b1;
  end

  assign in_ready = rdy_en && !clear && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // The first column of a row shifts in the freshly offered direction.
  // Later columns use the latched direction, so mid-row dir changes have no effect.
  assign dir_eff = (fill_cnt == '0) ? dir : dir_q;

  // The window is full after this accept if it was already full,
  // or if this accept supplies the K_W-th column.
  assign full_nxt = (state_q == ST_STREAM) || (fill_cnt == FILL_W'(K_W - 1));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_FILL;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next-state ----------------
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_FILL;
    end else if (accept) begin
      if (in_last)       state_d = ST_FILL;
      else if (full_nxt) state_d = ST_STREAM;
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    emit = 1'b0;
    if (!clear && accept && full_nxt && (stride_cnt == '0)) emit = 1'b1;
  end

  // Row counters. The stride phase only advances on accepts that leave the window full.
  // The column that completes the fill is phase 0, and a window is emitted for it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_cnt   <= '0;
      stride_cnt <= '0;
      win_cnt    <= '0;
      dir_q      <= DIR_FWD;
    end else if (clear) begin
      fill_cnt   <= '0;
      stride_cnt <= '0;
      win_cnt    <= '0;
      dir_q      <= DIR_FWD;
    end else if (accept) begin
      if (fill_cnt == '0) dir_q <= dir;
      if (in_last) begin
        fill_cnt   <= '0;
        stride_cnt <= '0;
        win_cnt    <= '0;
      end else begin
        if (fill_cnt != FILL_W'(K_W)) fill_cnt <= fill_cnt + 1'b1;
        if (full_nxt) begin
          if (stride_cnt == STR_W'(STRIDE - 1)) stride_cnt <= '0;
          else                                  stride_cnt <= stride_cnt + 1'b1;
        end else begin
          stride_cnt <= '0;
        end
        if (emit) win_cnt <= win_cnt + 1'b1;
      end
    end
  end

  win_shift_array #(
    .K_H    (K_H),
    .K_W    (K_W),
    .DATA_W (DATA_W)
  ) u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .shift_en (accept),
    .dir      (dir_eff),
    .in_col   (in_col),
    .win_nxt  (win_nxt)
  );

  // Output register. A new emit may overwrite a window that is being consumed
  // this cycle. A held window is never overwritten, because accept needs out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_win   <= '0;
      out_dir   <= 1'b0;
      out_idx   <= '0;
    end else if (clear) begin
      out_valid <= 1'b0;
      out_win   <= '0;
      out_dir   <= 1'b0;
      out_idx   <= '0;
    end else if (emit) begin
      out_valid <= 1'b1;
      out_win   <= win_nxt;
      out_dir   <= dir_eff;
      out_idx   <= win_cnt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_slide_win_buf.sv
// Directed bench for slide_win_buf (3x3 windows, 8-bit pixels), with STRIDE=1 and STRIDE=2 instances.
// Column k carries pixel 10*k+r on row r, so every expected window follows from (dir, last column).
// Stimulus comes from a table of per-cycle vectors plus hand-written backpressure and reset sequences.
module tb_slide_win_buf;

  logic        clk = 1'b0;
  logic        rst_n, clear, in_valid, in_last, dir, out_ready;
  logic [23:0] in_col;

  logic        rdy1, ov1, od1, rdy2, ov2, od2;
  logic [71:0] win1, win2;
  logic [7:0]  idx1, idx2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  slide_win_buf #(.K_H(3), .K_W(3), .DATA_W(8), .STRIDE(1), .IDX_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy1),
    .in_col(in_col), .in_last(in_last), .dir(dir), .out_valid(ov1), .out_ready(out_ready),
    .out_win(win1), .out_dir(od1), .out_idx(idx1)
  );

  slide_win_buf #(.K_H(3), .K_W(3), .DATA_W(8), .STRIDE(2), .IDX_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy2),
    .in_col(in_col), .in_last(in_last), .dir(dir), .out_valid(ov2), .out_ready(out_ready),
    .out_win(win2), .out_dir(od2), .out_idx(idx2)
  );

  typedef struct {
    logic clr, vld, last, dr;
    int   col;
    logic rdy;
    logic ev;  int eidx; logic edr; int ek;
    logic c2;
    logic ev2; int eidx2; int ek2;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [23:0] col_word(input int k);
    logic [23:0] w;
    for (int r = 0; r < 3; r++) w[r*8 +: 8] = 8'(10*k + r);
    return w;
  endfunction

  // Expected window whose most recent column is k.
  // Forward scans put the newest column at c=0; reverse scans put it at c=2.
  function automatic logic [71:0] exp_win(input logic d, input int k);
    logic [71:0] w;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[(r*3+c)*8 +: 8] = d ? 8'(10*(k-2+c) + r) : 8'(10*(k-c) + r);
    return w;
  endfunction

  function automatic vec_t mk(input logic clr, vld, input int col, input logic last, dr, rdy,
                              input logic ev, input int eidx, input logic edr, input int ek,
                              input logic c2, ev2, input int eidx2, input int ek2);
    vec_t v;
    v.clr = clr; v.vld = vld; v.col = col; v.last = last; v.dr = dr; v.rdy = rdy;
    v.ev = ev; v.eidx = eidx; v.edr = edr; v.ek = ek;
    v.c2 = c2; v.ev2 = ev2; v.eidx2 = eidx2; v.ek2 = ek2;
    return v;
  endfunction

  task automatic drive(input logic clr, vld, input int col, input logic last, dr, ordy);
    clear = clr; in_valid = vld; in_col = col_word(col); in_last = last; dir = dr; out_ready = ordy;
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Send one column with out_ready high, then check the registered result on dut1.
  task automatic push(input string nm, input int col, input logic last,
                      input logic ev, input int eidx, input int ek);
    drive(1'b0, 1'b1, col, last, 1'b0, 1'b1);
    tick();
    chk({nm, "_ovld"}, 72'(ov1), 72'(ev));
    if (ev) begin
      chk({nm, "_idx"}, 72'(idx1), 72'(eidx));
      chk({nm, "_win"}, win1, exp_win(1'b0, ek));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    chk("rst_ovld",  72'(ov1),  72'd0);
    chk("rst_rdy",   72'(rdy1), 72'd0);
    chk("rst_win",   win1,      72'd0);
    chk("rst_idx",   72'(idx1), 72'd0);
    chk("rst_dir",   72'(od1),  72'd0);
    rst_n = 1'b1;
    #1 chk("rel_rdy_now", 72'(rdy1), 72'd0);
    tick();
    chk("rel_rdy_next", 72'(rdy1), 72'd1);

    // Fields: clr vld col last dr rdy | ev eidx edr ek | c2 ev2 eidx2 ek2
    // Three windows at STRIDE=1; the STRIDE=2 instance emits only after c2 and c4.
    tbl.push_back(mk(1,0,0,0,0,0, 0,0,0,0, 1,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,1, 0,0,0,0, 1,0,0,0));
    tbl.push_back(mk(0,1,1,0,0,1, 0,0,0,0, 1,0,0,0));
    tbl.push_back(mk(0,1,2,0,0,1, 1,0,0,2, 1,1,0,2));
    tbl.push_back(mk(0,1,3,0,0,1, 1,1,0,3, 1,0,0,0));
    tbl.push_back(mk(0,1,4,1,0,1, 1,2,0,4, 1,1,1,4));
    tbl.push_back(mk(0,0,0,0,0,1, 0,0,0,0, 1,0,0,0));
    // Reverse scan; dir drops to 0 at c1 and must be ignored.
    tbl.push_back(mk(1,0,0,0,0,0, 0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,1,0,0,1,1, 0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,1,1,0,0,1, 0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,1,2,1,0,1, 1,0,1,2, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,1, 0,0,0,0, 0,0,0,0));
    // A short row (last at c1) gives no window; the next row starts at index 0.
    tbl.push_back(mk(1,0,0,0,0,0, 0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,1, 0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,1,1,1,0,1, 0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,1,5,0,0,1, 0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,1,6,0,0,1, 0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,1,7,1,0,1, 1,0,0,7, 0,0,0,0));
    // Clear with a valid column drops it; the next three columns form the first window.
    tbl.push_back(mk(1,0,0,0,0,0, 0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,1, 0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,1,1,0,0,1, 0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(1,1,2,0,0,0, 0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,1,2,0,0,1, 0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,1,3,0,0,1, 0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,1,4,1,0,1, 1,0,0,4, 0,0,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].clr, tbl[i].vld, tbl[i].col, tbl[i].last, tbl[i].dr, 1'b1);
      #1 chk($sformatf("v%0d_rdy", i), 72'(rdy1), 72'(tbl[i].rdy));
      tick();
      chk($sformatf("v%0d_ovld", i), 72'(ov1), 72'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("v%0d_idx", i), 72'(idx1), 72'(tbl[i].eidx));
        chk($sformatf("v%0d_dir", i), 72'(od1),  72'(tbl[i].edr));
        chk($sformatf("v%0d_win", i), win1, exp_win(tbl[i].edr, tbl[i].ek));
      end
      if (tbl[i].c2) begin
        chk($sformatf("v%0d_s2_ovld", i), 72'(ov2), 72'(tbl[i].ev2));
        if (tbl[i].ev2) begin
          chk($sformatf("v%0d_s2_idx", i), 72'(idx2), 72'(tbl[i].eidx2));
          chk($sformatf("v%0d_s2_win", i), win2, exp_win(1'b0, tbl[i].ek2));
        end
      end
    end

    // Backpressure: hold the first window for 4 cycles while c3 is offered.
    drive(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    tick();
    push("bp_c0", 0, 1'b0, 1'b0, 0, 0);
    push("bp_c1", 1, 1'b0, 1'b0, 0, 0);
    push("bp_c2", 2, 1'b0, 1'b1, 0, 2);
    drive(1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("bp_hold%0d_rdy", i), 72'(rdy1), 72'd0);
      tick();
      chk($sformatf("bp_hold%0d_ovld", i), 72'(ov1), 72'd1);
      chk($sformatf("bp_hold%0d_idx", i),  72'(idx1), 72'd0);
      chk($sformatf("bp_hold%0d_win", i),  win1, exp_win(1'b0, 2));
    end
    out_ready = 1'b1;
    #1 chk("bp_resume_rdy", 72'(rdy1), 72'd1);
    tick();
    chk("bp_c3_ovld", 72'(ov1), 72'd1);
    chk("bp_c3_idx",  72'(idx1), 72'd1);
    chk("bp_c3_win",  win1, exp_win(1'b0, 3));
    push("bp_c4", 4, 1'b1, 1'b1, 2, 4);
    drive(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("bp_idle_ovld", 72'(ov1), 72'd0);

    // Reset in the middle of a row, with a window pending; afterwards the block starts a fresh row.
    drive(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    tick();
    push("mr_c0", 0, 1'b0, 1'b0, 0, 0);
    push("mr_c1", 1, 1'b0, 1'b0, 0, 0);
    push("mr_c2", 2, 1'b0, 1'b1, 0, 2);
    push("mr_c3", 3, 1'b0, 1'b1, 1, 3);
    drive(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_rst_ovld", 72'(ov1),  72'd0);
    chk("mr_rst_win",  win1,      72'd0);
    chk("mr_rst_idx",  72'(idx1), 72'd0);
    chk("mr_rst_rdy",  72'(rdy1), 72'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("mr_rel_rdy_now", 72'(rdy1), 72'd0);
    tick();
    chk("mr_rel_rdy_next", 72'(rdy1), 72'd1);
    push("mr_c5", 5, 1'b0, 1'b0, 0, 0);
    push("mr_c6", 6, 1'b0, 1'b0, 0, 0);
    push("mr_c7", 7, 1'b1, 1'b1, 0, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
